// File: rtl/branch_predictor_if.sv
// Pipeline-facing signals of the branch predictor: IF lookup, EX resolution and statistics.
// The master side is the pipeline (or bench); the slave side is the predictor.
interface branch_predictor_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic [31:0]      if_pc;
  logic             predict_taken;
  logic [31:0]      predict_target;
  logic             ex_branch;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             ex_pred_taken;
  logic             branch_predicted;
  logic [31:0]      correct_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output stall, if_pc, ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken,
    input  predict_taken, predict_target, branch_predicted, correct_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  stall, if_pc, ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken,
    output predict_taken, predict_target, branch_predicted, correct_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: IF-stage prediction,
// EX-stage resolution/update, redirect PC and saturating performance counters.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input logic              CLK,
  input logic              nRST,
  branch_predictor_if.slave bp
);
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int          TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  logic             r_valid  [DEPTH];
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [31:0]      r_target [DEPTH];
  cnt_e             r_cnt    [DEPTH];
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_if_hit;
  logic             w_ex_hit;
  logic             w_update;
  logic             w_mispredict;
  cnt_e             w_cnt_next;

  assign w_if_idx = bp.if_pc[IDX_W+1:2];
  assign w_if_tag = bp.if_pc[31:IDX_W+2];
  assign w_ex_idx = bp.ex_pc[IDX_W+1:2];
  assign w_ex_tag = bp.ex_pc[31:IDX_W+2];

  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  // A stalled branch stays in EX; it is counted only on the edge it leaves.
  assign w_update     = bp.ex_branch && !bp.stall;
  assign w_mispredict = bp.ex_pred_taken != bp.ex_taken;

  always_comb begin
    bp.predict_taken    = 1'b0;
    bp.predict_target   = '0;
    bp.branch_predicted = 1'b1;
    bp.correct_pc       = bp.ex_pc + 32'd4;
    if (w_if_hit) begin
      bp.predict_taken  = r_cnt[w_if_idx][1];
      bp.predict_target = r_target[w_if_idx];
    end
    if (bp.ex_branch && w_mispredict) begin
      bp.branch_predicted = 1'b0;
    end
    if (bp.ex_taken) begin
      bp.correct_pc = bp.ex_target;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt[w_ex_idx];
    if (bp.ex_taken) begin
      if (r_cnt[w_ex_idx] != CNT_ST) begin
        w_cnt_next = cnt_e'(r_cnt[w_ex_idx] + 2'd1);
      end
    end else begin
      if (r_cnt[w_ex_idx] != CNT_SNT) begin
        w_cnt_next = cnt_e'(r_cnt[w_ex_idx] - 2'd1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CNT_WNT;
      end
    end else if (w_update) begin
      if (w_ex_hit) begin
        r_cnt[w_ex_idx] <= w_cnt_next;
        if (bp.ex_taken) begin
          r_target[w_ex_idx] <= bp.ex_target;
        end
      end else if (bp.ex_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= bp.ex_target;
        r_cnt[w_ex_idx]    <= CNT_WT;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_update) begin
      if (r_branch_count != '1) begin
        r_branch_count <= r_branch_count + 1'b1;
      end
      if (w_mispredict && (r_mispredict_count != '1)) begin
        r_mispredict_count <= r_mispredict_count + 1'b1;
      end
    end
  end

  assign bp.branch_count     = r_branch_count;
  assign bp.mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared against a per-entry behavioural model of the predictor.
module tb_branch_predictor;
  localparam int IDX_W = 4;
  localparam int CNT_W = 16;
  localparam int DEPTH = 1 << IDX_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic CLK;
  logic nRST;

  branch_predictor_if #(.CNT_W(CNT_W)) bus ();

  branch_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bp   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: each slot remembers the full PC that owns it and a 0..3 confidence.
  bit          m_valid [DEPTH];
  logic [31:0] m_pc    [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  int          m_branches;
  int          m_misses;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int s = slot(pc);
    return m_valid[s] && ((m_pc[s] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[slot(pc)] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_branches = 0;
    m_misses   = 0;
  endtask

  task automatic model_update();
    int s = slot(bus.ex_pc);
    if (m_hit(bus.ex_pc)) begin
      if (bus.ex_taken) begin
        m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
        m_tgt[s] = bus.ex_target;
      end else begin
        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
      end
    end else if (bus.ex_taken) begin
      m_valid[s] = 1'b1; m_pc[s] = bus.ex_pc; m_tgt[s] = bus.ex_target; m_ctr[s] = 2;
    end
    if (m_branches < CMAX) m_branches++;
    if (bus.ex_pred_taken != bus.ex_taken && m_misses < CMAX) m_misses++;
  endtask

  // One clock: the model follows the DUT's update rule, then inputs may change at +1.
  task automatic tick();
    @(posedge CLK);
    if (nRST && bus.ex_branch && !bus.stall) model_update();
    #1;
  endtask

  task automatic drive_ex(input bit br, input logic [31:0] pc, input bit tk,
                          input logic [31:0] tgt, input bit pt);
    bus.ex_branch = br; bus.ex_pc = pc; bus.ex_taken = tk;
    bus.ex_target = tgt; bus.ex_pred_taken = pt;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    #1;
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.stall = 1'b0;
    bus.if_pc = 32'h40;
    drive_ex(1'b0, '0, 1'b0, '0, 1'b0);
    nRST = 1'b0;
    model_reset();
    #2;
    checks++;
    if (bus.predict_taken !== 1'b0 || bus.predict_target !== 32'h0) begin
      errors++;
      $display("FAIL reset_predict: got taken=%0b target=%h want 0/0", bus.predict_taken, bus.predict_target);
    end
    checks++;
    if (bus.branch_predicted !== 1'b1) begin
      errors++;
      $display("FAIL reset_branch_predicted: got %0b want 1", bus.branch_predicted);
    end
    checks++;
    if (bus.branch_count !== '0 || bus.mispredict_count !== '0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.branch_count, bus.mispredict_count);
    end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_first_alloc();
    bus.if_pc = 32'h40;
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
    #1;
    checks++;
    if (bus.branch_predicted !== 1'b0 || bus.correct_pc !== 32'h80) begin
      errors++;
      $display("FAIL alloc_resolve: got bp=%0b cpc=%h want 0/00000080", bus.branch_predicted, bus.correct_pc);
    end
    tick();
    drive_ex(1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    checks++;
    if (bus.predict_taken !== 1'b1 || bus.predict_target !== 32'h80) begin
      errors++;
      $display("FAIL alloc_lookup: got taken=%0b target=%h want 1/00000080", bus.predict_taken, bus.predict_target);
    end
    checks++;
    if (bus.mispredict_count !== 16'd1 || bus.branch_count !== 16'd1) begin
      errors++;
      $display("FAIL alloc_counts: got br=%0d mis=%0d want 1/1", bus.branch_count, bus.mispredict_count);
    end
  endtask

  task automatic test_counter_path();
    bit want [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bus.if_pc = 32'h40;
    for (int i = 0; i < 7; i++) begin
      drive_ex(1'b1, 32'h40, (i < 4), 32'h80, 1'b1);
      tick();
      drive_ex(1'b0, '0, 1'b0, '0, 1'b0);
      #1;
      checks++;
      if (bus.predict_taken !== want[i] || bus.predict_taken !== m_pred(32'h40)) begin
        errors++;
        $display("FAIL counter_path[%0d]: got taken=%0b want %0b", i, bus.predict_taken, want[i]);
      end
    end
  endtask

  task automatic test_alias();
    bus.if_pc = 32'h80;
    #1;
    checks++;
    if (bus.predict_taken !== 1'b0 || bus.predict_target !== 32'h0) begin
      errors++;
      $display("FAIL alias_lookup: got taken=%0b target=%h want 0/0", bus.predict_taken, bus.predict_target);
    end
    drive_ex(1'b1, 32'h80, 1'b0, 32'h200, 1'b0);
    tick();
    drive_ex(1'b0, '0, 1'b0, '0, 1'b0);
    bus.if_pc = 32'h40;
    #1;
    checks++;
    if (bus.predict_target !== 32'h80) begin
      errors++;
      $display("FAIL alias_intact: got target=%h want 00000080", bus.predict_target);
    end
  endtask

  task automatic test_stall();
    int start = m_branches;
    drive_ex(1'b1, 32'h48, 1'b1, 32'h300, 1'b1);
    bus.stall = 1'b1;
    repeat (3) tick();
    bus.stall = 1'b0;
    tick();
    drive_ex(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    checks++;
    if (int'(bus.branch_count) !== start + 1) begin
      errors++;
      $display("FAIL stall_once: got br=%0d want %0d", bus.branch_count, start + 1);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.if_pc = 32'h100;
    drive_ex(1'b1, 32'h100, 1'b1, 32'h180, 1'b0);
    #1;
    checks++;
    if (bus.predict_taken !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_before: got taken=%0b want 0", bus.predict_taken);
    end
    tick();
    drive_ex(1'b1, 32'h100, 1'b0, 32'h180, 1'b1);
    #1;
    checks++;
    if (bus.predict_taken !== 1'b1 || bus.predict_target !== 32'h180) begin
      errors++;
      $display("FAIL same_cycle_after: got taken=%0b target=%h want 1/00000180", bus.predict_taken, bus.predict_target);
    end
    checks++;
    if (bus.correct_pc !== 32'h104) begin
      errors++;
      $display("FAIL not_taken_cpc: got %h want 00000104", bus.correct_pc);
    end
    tick();
    drive_ex(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] pcs [8] = '{32'h40, 32'h80, 32'h100, 32'h44, 32'h1040, 32'h7C, 32'hFFFF_FFC0, 32'h42};
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      bus.if_pc = pcs[$urandom_range(7)];
      bus.stall = ($urandom_range(3) == 0);
      drive_ex($urandom_range(1), pcs[$urandom_range(7)], $urandom_range(1),
               {$urandom_range(32'hFFFF), 2'b00}, $urandom_range(1));
      #1;
      checks++;
      if (bus.predict_taken !== m_pred(bus.if_pc) || bus.predict_target !== m_ptgt(bus.if_pc)
          || bus.branch_predicted !== (!bus.ex_branch || (bus.ex_pred_taken == bus.ex_taken))
          || bus.correct_pc !== (bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4)
          || int'(bus.branch_count) !== m_branches || int'(bus.mispredict_count) !== m_misses) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL random[%0d]: got pt=%0b tgt=%h bp=%0b cpc=%h br=%0d mis=%0d want pt=%0b tgt=%h br=%0d mis=%0d",
                   n, bus.predict_taken, bus.predict_target, bus.branch_predicted, bus.correct_pc,
                   bus.branch_count, bus.mispredict_count, m_pred(bus.if_pc), m_ptgt(bus.if_pc),
                   m_branches, m_misses);
      end
      tick();
    end
    bus.stall = 1'b0;
    drive_ex(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.if_pc = 32'h200;
    drive_ex(1'b1, 32'h200, 1'b1, 32'h400, 1'b1);
    tick();
    drive_ex(1'b0, '0, 1'b0, '0, 1'b0);
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.predict_taken !== 1'b0 || bus.predict_target !== 32'h0
        || bus.branch_count !== '0 || bus.mispredict_count !== '0) begin
      errors++;
      $display("FAIL reset_mid: got taken=%0b target=%h br=%0d mis=%0d want 0/0/0/0",
               bus.predict_taken, bus.predict_target, bus.branch_count, bus.mispredict_count);
    end
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_alloc();
    test_counter_path();
    test_alias();
    test_stall();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Dynamic branch predictor for the 5-stage MIPS pipeline. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- IF stage: predicts BEQ/BNE direction and target from the fetch PC.
- EX stage: resolves the prediction against the actual outcome, updates its tables, and drives branch_predicted into the hazard unit. The hazard unit uses branch_predicted to decide whether to flush ID/EX.
- Also supplies the PC to redirect fetch to on a mispredict.

Parameters:
IDX_W, 4, index bits; table depth = 2**IDX_W entries
CNT_W, 16, width of the performance counters

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
stall  input  1  pipeline stall from hazard unit; EX instruction held, so no table/counter update
if_pc  input  32  fetch-stage PC
predict_taken  output  1  IF prediction: branch taken
predict_target  output  32  IF predicted target (valid when predict_taken)
ex_branch  input  1  EX stage holds a BEQ/BNE
ex_pc  input  32  PC of the EX-stage branch
ex_taken  input  1  resolved outcome
ex_target  input  32  resolved branch target
ex_pred_taken  input  1  prediction made for this instruction, carried down the pipeline
branch_predicted  output  1  1 = EX prediction was correct (or no branch in EX)
correct_pc  output  32  redirect PC: ex_target if ex_taken, else ex_pc+4
branch_count  output  CNT_W  resolved branches
mispredict_count  output  CNT_W  mispredicted branches

Behaviour:
- Reset (async, nRST=0):
  - All valid bits = 0, all counters = 2'b01 (weakly not-taken), tags/targets = 0.
  - branch_count = mispredict_count = 0.
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] ignored.
- Lookup (combinational from current table state):
  - hit = valid[idx] && tag[idx]==if_pc tag.
  - predict_taken = hit && cnt[idx][1].
  - predict_target = hit ? target[idx] : 0.
- Resolution (combinational):
  - branch_predicted = !ex_branch || (ex_pred_taken == ex_taken).
  - correct_pc = ex_taken ? ex_target : ex_pc+4, computed regardless of ex_branch.
- Update: occurs on the rising edge when ex_branch && !stall. Exactly one update per branch, even if it sits in EX across several stall cycles.
  - Hit on ex_pc: counter saturating increment if ex_taken, saturating decrement otherwise (11 stays 11, 00 stays 00). Target overwritten with ex_target if ex_taken.
  - Miss and ex_taken: allocate/replace the entry: valid=1, tag, target=ex_target, cnt=2'b10.
  - Miss and not taken: no change.
- Statistics, on the same update edge:
  - branch_count += 1.
  - mispredict_count += 1 if ex_pred_taken != ex_taken.
  - Both saturate at all-ones; no wrap.
- Same-cycle lookup and update on the same index: lookup returns pre-update state (read-before-write). New state is visible the cycle after the edge.
- Reset mid-operation: all state clears immediately; outputs reflect the reset table in the same cycle.
- ex_branch=0: no state change; branch_predicted=1.

Test Plan:
1. Reset, if_pc=0x40 -> predict_taken=0, predict_target=0, branch_predicted=1, counts 0.
2. EX: ex_pc=0x40, ex_taken=1, ex_target=0x80, ex_pred_taken=0, one edge -> branch_predicted=0 before the edge, correct_pc=0x80; after the edge, if_pc=0x40 gives predict_taken=1, predict_target=0x80, mispredict_count=1.
3. Four more taken updates, then three not-taken updates at 0x40 -> counter path 10→11→11→11→11→10→01→00; predict_taken after the final update = 0.
4. Alias: entry at 0x40 valid; if_pc=0x40+(4<<IDX_W)=0x80 -> tag mismatch, predict_taken=0. A not-taken update at that PC leaves the 0x40 entry intact.
5. stall=1 for 3 cycles with ex_branch=1, then stall=0 for 1 cycle -> branch_count increments by exactly 1.
6. Same cycle: if_pc=ex_pc=0x100, entry empty, ex_taken=1 -> predict_taken=0 that cycle, 1 the next cycle. Not-taken ex_pc=0x100 -> correct_pc=0x104.
